// File: rtl/refresh_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// refresh_sched_pkg
//   Shared definitions for the refresh scheduler:
//     - DRAM command opcodes driven on cmd_op
//     - FSM state encoding
//     - width helper for the refresh-debt counter
//   No ports (package).
// ---------------------------------------------------------------------------
package refresh_sched_pkg;

   localparam logic [2:0] CMD_NOP           = 3'd0;
   localparam logic [2:0] CMD_READ          = 3'd1;
   localparam logic [2:0] CMD_WRITE         = 3'd2;
   localparam logic [2:0] CMD_PRECHARGE_ALL = 3'd3;
   localparam logic [2:0] CMD_REFRESH       = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOST_CMD,
      ST_HOST_WAIT,
      ST_PRE,
      ST_TRP_WAIT,
      ST_REF,
      ST_TRFC_WAIT
   } state_e;

   // Bits needed to hold a debt value in 0..max_owed.
   function automatic int unsigned owed_width(input int unsigned max_owed);
      return $clog2(max_owed + 1);
   endfunction

   // Debt width for the default saturation limit of 8.
   localparam int unsigned OWED_W = owed_width(8);

endpackage

// File: rtl/refresh_debt_counter.sv
// ---------------------------------------------------------------------------
// refresh_debt_counter
//   Free-running TREFI interval timer plus the saturating refresh-debt count.
//   Every TREFI cycles one more refresh is owed; a completed refresh (i_dec)
//   pays one back. A tick that arrives with the debt already at MAX_OWED is
//   lost and latches the sticky overflow flag.
// Ports
//   i_clk       clock
//   i_rst_n     async active-low reset
//   i_dec       1-cycle pulse: a refresh has just completed
//   o_owed      current refresh debt, 0..MAX_OWED
//   o_overflow  sticky: tick seen while debt was saturated
// ---------------------------------------------------------------------------
module refresh_debt_counter #(
   parameter int unsigned TREFI    = 7800,
   parameter int unsigned MAX_OWED = 8,
   parameter int unsigned OWED_W   = $clog2(MAX_OWED + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_dec,
   output logic [OWED_W-1:0] o_owed,
   output logic              o_overflow
);

   localparam int unsigned       TICK_W    = (TREFI > 1) ? $clog2(TREFI) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TREFI - 1);
   localparam logic [OWED_W-1:0] OWED_MAX  = OWED_W'(MAX_OWED);

   logic [TICK_W-1:0] r_tick_cnt;
   logic [OWED_W-1:0] r_owed;
   logic              r_overflow;
   logic              w_tick;

   assign w_tick     = (r_tick_cnt == TICK_LAST);
   assign o_owed     = r_owed;
   assign o_overflow = r_overflow;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tick_cnt <= '0;
         r_owed     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;

         if (w_tick && (r_owed == OWED_MAX))
            r_overflow <= 1'b1;

         // A tick and a completion in the same cycle cancel out.
         if (w_tick && !i_dec) begin
            if (r_owed != OWED_MAX)
               r_owed <= r_owed + 1'b1;
         end else if (i_dec && !w_tick) begin
            if (r_owed != '0)
               r_owed <= r_owed - 1'b1;
         end
      end
   end

endmodule

// File: rtl/refresh_scheduler.sv
// ---------------------------------------------------------------------------
// refresh_scheduler
//   Shares one DRAM command port between host accesses and periodic refresh.
//   Refresh is deferred while the host has a request pending, unless the
//   debt has reached URGENT; then PRECHARGE_ALL + REFRESH pre-empt the host.
//   Host accesses in flight (command or completion wait) are never broken.
// Ports
//   sys_clk, sys_rst_n            clock, async active-low reset
//   host_req_valid/ready/we/addr  host request (ready is combinational)
//   mem_done                      1-cycle pulse: host access complete
//   cmd_valid/ready/op/addr       DRAM command channel (registered outputs)
//   refresh_busy                  high from PRE through the TRFC wait
//   owed_cnt                      current refresh debt
//   refresh_overflow              sticky: debt tick lost at saturation
// ---------------------------------------------------------------------------
module refresh_scheduler
   import refresh_sched_pkg::*;
#(
   parameter  int unsigned ADDR_W    = 24,
   parameter  int unsigned TREFI     = 7800,
   parameter  int unsigned TRP       = 3,
   parameter  int unsigned TRFC      = 350,
   parameter  int unsigned MAX_OWED  = 8,
   parameter  int unsigned URGENT    = 4,
   localparam int unsigned OWED_BITS = owed_width(MAX_OWED)
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 host_req_valid,
   output logic                 host_req_ready,
   input  logic                 host_req_we,
   input  logic [ADDR_W-1:0]    host_req_addr,
   input  logic                 mem_done,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [2:0]           cmd_op,
   output logic [ADDR_W-1:0]    cmd_addr,
   output logic                 refresh_busy,
   output logic [OWED_BITS-1:0] owed_cnt,
   output logic                 refresh_overflow
);

   localparam int unsigned WAIT_MAX = (TRP > TRFC) ? TRP : TRFC;
   localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

   state_e              r_state;
   logic                r_cmd_valid;
   logic [2:0]          r_cmd_op;
   logic [ADDR_W-1:0]   r_cmd_addr;
   logic                r_busy;
   logic [WAIT_W-1:0]   r_wait;

   logic [OWED_BITS-1:0] w_owed;
   logic                 w_overflow;
   logic                 w_urgent;
   logic                 w_want_ref;
   logic                 w_dec;

   refresh_debt_counter #(
      .TREFI    (TREFI),
      .MAX_OWED (MAX_OWED),
      .OWED_W   (OWED_BITS)
   ) u_debt (
      .i_clk      (sys_clk),
      .i_rst_n    (sys_rst_n),
      .i_dec      (w_dec),
      .o_owed     (w_owed),
      .o_overflow (w_overflow)
   );

   // Refresh wins in IDLE when it is urgent, or when there is debt and the
   // host has nothing waiting.
   assign w_urgent   = (w_owed >= OWED_BITS'(URGENT));
   assign w_want_ref = (w_owed != '0) && (w_urgent || !host_req_valid);

   // NOTE: combinational outputs are plain continuous assigns, so every
   // path is fully specified and no latch can be inferred.
   assign host_req_ready = (r_state == ST_IDLE) && host_req_valid && !w_want_ref;

   // Debt is paid back on the last TRFC wait cycle, the same edge that
   // returns the FSM to IDLE.
   assign w_dec = (r_state == ST_TRFC_WAIT) && (r_wait == '0);

   assign cmd_valid        = r_cmd_valid;
   assign cmd_op           = r_cmd_op;
   assign cmd_addr         = r_cmd_addr;
   assign refresh_busy     = r_busy;
   assign owed_cnt         = w_owed;
   assign refresh_overflow = w_overflow;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state     <= ST_IDLE;
         r_cmd_valid <= 1'b0;
         r_cmd_op    <= CMD_NOP;
         r_cmd_addr  <= '0;
         r_busy      <= 1'b0;
         r_wait      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_want_ref) begin
                  r_state     <= ST_PRE;
                  r_cmd_valid <= 1'b1;
                  r_cmd_op    <= CMD_PRECHARGE_ALL;
                  r_cmd_addr  <= '0;
                  r_busy      <= 1'b1;
               end else if (host_req_valid) begin
                  r_state     <= ST_HOST_CMD;
                  r_cmd_valid <= 1'b1;
                  r_cmd_op    <= host_req_we ? CMD_WRITE : CMD_READ;
                  r_cmd_addr  <= host_req_addr;
               end
            end
            ST_HOST_CMD: begin
               if (cmd_ready) begin
                  r_state     <= ST_HOST_WAIT;
                  r_cmd_valid <= 1'b0;
                  r_cmd_op    <= CMD_NOP;
                  r_cmd_addr  <= '0;
               end
            end
            ST_HOST_WAIT: begin
               if (mem_done)
                  r_state <= ST_IDLE;
            end
            ST_PRE: begin
               if (cmd_ready) begin
                  r_state     <= ST_TRP_WAIT;
                  r_cmd_valid <= 1'b0;
                  r_cmd_op    <= CMD_NOP;
                  r_wait      <= WAIT_W'(TRP - 1);
               end
            end
            ST_TRP_WAIT: begin
               if (r_wait == '0) begin
                  r_state     <= ST_REF;
                  r_cmd_valid <= 1'b1;
                  r_cmd_op    <= CMD_REFRESH;
               end else begin
                  r_wait <= r_wait - 1'b1;
               end
            end
            ST_REF: begin
               if (cmd_ready) begin
                  r_state     <= ST_TRFC_WAIT;
                  r_cmd_valid <= 1'b0;
                  r_cmd_op    <= CMD_NOP;
                  r_wait      <= WAIT_W'(TRFC - 1);
               end
            end
            ST_TRFC_WAIT: begin
               if (r_wait == '0) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_wait <= r_wait - 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cmd_valid <= 1'b0;
               r_cmd_op    <= CMD_NOP;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_refresh_scheduler.sv
// ---------------------------------------------------------------------------
// tb_refresh_scheduler
//   Self-checking bench for refresh_scheduler. A reference model describes
//   the command port as a script of expected slots (handshake, fixed gap,
//   wait-for-done) queued whenever the scheduler starts a host access or a
//   refresh; debt follows from cycle arithmetic. Outputs are compared against
//   the model every cycle, plus literal checks for a few hand-timed events.
// ---------------------------------------------------------------------------
module tb_refresh_scheduler;

   localparam int ADDR_W    = 16;
   localparam int TREFI     = 20;
   localparam int TRP       = 3;
   localparam int TRFC      = 12;
   localparam int MAX_OWED  = 8;
   localparam int URGENT    = 4;
   localparam int OWED_BITS = $clog2(MAX_OWED + 1);

   logic                 sys_clk = 1'b0;
   logic                 sys_rst_n;
   logic                 host_req_valid;
   logic                 host_req_ready;
   logic                 host_req_we;
   logic [ADDR_W-1:0]    host_req_addr;
   logic                 mem_done;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [2:0]           cmd_op;
   logic [ADDR_W-1:0]    cmd_addr;
   logic                 refresh_busy;
   logic [OWED_BITS-1:0] owed_cnt;
   logic                 refresh_overflow;

   always #5 sys_clk = ~sys_clk;

   refresh_scheduler #(
      .ADDR_W   (ADDR_W),
      .TREFI    (TREFI),
      .TRP      (TRP),
      .TRFC     (TRFC),
      .MAX_OWED (MAX_OWED),
      .URGENT   (URGENT)
   ) dut (
      .sys_clk          (sys_clk),
      .sys_rst_n        (sys_rst_n),
      .host_req_valid   (host_req_valid),
      .host_req_ready   (host_req_ready),
      .host_req_we      (host_req_we),
      .host_req_addr    (host_req_addr),
      .mem_done         (mem_done),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_op           (cmd_op),
      .cmd_addr         (cmd_addr),
      .refresh_busy     (refresh_busy),
      .owed_cnt         (owed_cnt),
      .refresh_overflow (refresh_overflow)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {K_HS, K_GAP, K_DONE} kind_e;
   typedef struct {
      kind_e             kind;  // handshake / fixed gap / wait for mem_done
      logic [2:0]        op;
      logic [ADDR_W-1:0] addr;
      bit                busy;
      bit                last;  // popping this slot completes a refresh
   } item_t;

   item_t   script[$];
   int      m_owed;
   bit      m_ovf;
   longint  m_cyc;  // clock edges since reset release

   function automatic void push_refresh();
      script.push_back('{kind: K_HS, op: 3'd3, addr: '0, busy: 1'b1, last: 1'b0});
      for (int i = 0; i < TRP; i++)
         script.push_back('{kind: K_GAP, op: 3'd0, addr: '0, busy: 1'b1, last: 1'b0});
      script.push_back('{kind: K_HS, op: 3'd4, addr: '0, busy: 1'b1, last: 1'b0});
      for (int i = 0; i < TRFC; i++)
         script.push_back('{kind: K_GAP, op: 3'd0, addr: '0, busy: 1'b1, last: (i == TRFC - 1)});
   endfunction

   function automatic void push_host(input bit we, input logic [ADDR_W-1:0] addr);
      script.push_back('{kind: K_HS, op: (we ? 3'd2 : 3'd1), addr: addr, busy: 1'b0, last: 1'b0});
      script.push_back('{kind: K_DONE, op: 3'd0, addr: '0, busy: 1'b0, last: 1'b0});
   endfunction

   // Compare on the falling edge, then advance the model across the next rising edge.
   always @(negedge sys_clk) begin : cmp
      bit                want_ref, tick, dec, pop;
      bit                e_valid, e_ready, e_busy;
      logic [2:0]        e_op;
      logic [ADDR_W-1:0] e_addr;
      item_t             it;
      if (!sys_rst_n) begin
         script.delete();
         m_owed = 0;
         m_ovf  = 1'b0;
         m_cyc  = 0;
      end else begin
         want_ref = (m_owed > 0) && ((m_owed >= URGENT) || !host_req_valid);
         if (script.size() == 0) begin
            e_valid = 1'b0; e_op = 3'd0; e_addr = '0; e_busy = 1'b0;
            e_ready = host_req_valid && !want_ref;
         end else begin
            it      = script[0];
            e_valid = (it.kind == K_HS);
            e_op    = e_valid ? it.op : 3'd0;
            e_addr  = e_valid ? it.addr : '0;
            e_busy  = it.busy;
            e_ready = 1'b0;
         end
         check("cmd_valid", 64'(cmd_valid), 64'(e_valid));
         check("cmd_op", 64'(cmd_op), 64'(e_op));
         check("cmd_addr", 64'(cmd_addr), 64'(e_addr));
         check("host_req_ready", 64'(host_req_ready), 64'(e_ready));
         check("refresh_busy", 64'(refresh_busy), 64'(e_busy));
         check("owed_cnt", 64'(owed_cnt), 64'(m_owed));
         check("refresh_overflow", 64'(refresh_overflow), 64'(m_ovf));

         tick = ((m_cyc % TREFI) == TREFI - 1);
         dec  = 1'b0;
         if (script.size() == 0) begin
            if (want_ref)            push_refresh();
            else if (host_req_valid) push_host(host_req_we, host_req_addr);
         end else begin
            it = script[0];
            case (it.kind)
               K_HS:    pop = cmd_ready;
               K_GAP:   pop = 1'b1;
               default: pop = mem_done;
            endcase
            if (pop) begin
               dec = it.last;
               void'(script.pop_front());
            end
         end
         if (tick && m_owed == MAX_OWED) m_ovf = 1'b1;
         m_owed = m_owed + int'(tick) - int'(dec);
         if (m_owed > MAX_OWED) m_owed = MAX_OWED;
         m_cyc++;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      sys_rst_n      = 1'b0;
      host_req_valid = 1'b0;
      host_req_we    = 1'b0;
      host_req_addr  = '0;
      mem_done       = 1'b0;
      cmd_ready      = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;

      // Idle host: first tick at edge 19, PRE presented after edge 20,
      // REF after edge 24, debt repaid at edge 37.
      @(negedge sys_clk);
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_owed", 64'(owed_cnt), 64'd0);
      check("rst_busy", 64'(refresh_busy), 64'd0);
      repeat (20) @(negedge sys_clk);
      check("c20_owed", 64'(owed_cnt), 64'd1);
      check("c20_valid", 64'(cmd_valid), 64'd0);
      @(negedge sys_clk);
      check("c21_valid", 64'(cmd_valid), 64'd1);
      check("c21_op_pre", 64'(cmd_op), 64'd3);
      check("c21_busy", 64'(refresh_busy), 64'd1);
      repeat (4) @(negedge sys_clk);
      check("c25_valid", 64'(cmd_valid), 64'd1);
      check("c25_op_ref", 64'(cmd_op), 64'd4);
      repeat (12) @(negedge sys_clk);
      check("c37_busy", 64'(refresh_busy), 64'd1);
      check("c37_owed", 64'(owed_cnt), 64'd1);
      @(negedge sys_clk);
      check("c38_owed", 64'(owed_cnt), 64'd0);
      check("c38_busy", 64'(refresh_busy), 64'd0);

      // Stall PRE so debt saturates and further ticks overflow.
      @(posedge sys_clk);
      #1 cmd_ready = 1'b0;
      repeat (200) @(negedge sys_clk);
      check("sat_owed", 64'(owed_cnt), 64'd8);
      check("sat_overflow", 64'(refresh_overflow), 64'd1);
      check("sat_op_pre", 64'(cmd_op), 64'd3);

      // Release PRE, then reset asynchronously in the middle of the TRFC wait.
      @(posedge sys_clk);
      #1 cmd_ready = 1'b1;
      repeat (8) @(negedge sys_clk);
      check("trfc_busy", 64'(refresh_busy), 64'd1);
      #2 sys_rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(cmd_valid), 64'd0);
      check("arst_busy", 64'(refresh_busy), 64'd0);
      check("arst_owed", 64'(owed_cnt), 64'd0);
      check("arst_overflow", 64'(refresh_overflow), 64'd0);
      repeat (2) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;

      // Randomised traffic: a saturated-host stretch, then alternating
      // light and heavy host load with random back-pressure and completions.
      for (int c = 0; c < 3000; c++) begin
         @(posedge sys_clk);
         #1;
         if (c < 600)
            host_req_valid = 1'b1;
         else if (((c / 200) % 2) == 1)
            host_req_valid = ($urandom_range(0, 3) == 0);
         else
            host_req_valid = ($urandom_range(0, 3) != 0);
         host_req_we   = 1'($urandom);
         host_req_addr = ADDR_W'($urandom);
         cmd_ready     = ($urandom_range(0, 3) != 0);
         mem_done      = ($urandom_range(0, 2) == 0);
      end

      @(negedge sys_clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
